// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, syncs and frame-aligned strobes from a divided system clock.
module vga_timing_gen #(
   parameter int CLK_DIV     = 4,
   parameter int H_VIS       = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_VIS       = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter logic SYNC_POL  = 1'b0,
   parameter int TICK_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       valid,
   output logic       hsync,
   output logic       vsync,
   output logic       pix_en,
   output logic       frame_start,
   output logic       vblank,
   output logic       game_tick,
   output logic [7:0] frame_cnt
);
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int TW = $clog2(TICK_FRAMES) > 6 ? $clog2(TICK_FRAMES) : 6;
   localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TICK_FRAMES - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
   localparam logic [9:0] H_VEND = 10'(H_VIS);
   localparam logic [9:0] V_VEND = 10'(V_VIS);
   localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic          valid_q, valid_d, hsync_q, hsync_d, vsync_q, vsync_d, vblank_q, vblank_d;
   logic          frame_start_q, frame_start_d, game_tick_q, game_tick_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic [TW-1:0] tk_q, tk_d;
   logic          h_wrap, wrap;

   assign pix_en = div_q == D_LAST;

   // Status flags are computed from the next counter values so they change on the same edge as the counters.
   always_comb begin
      h_wrap        = h_cnt_q == H_LAST;
      wrap          = pix_en && h_wrap && v_cnt_q == V_LAST;
      div_d         = pix_en ? '0 : div_q + DW'(1);
      h_cnt_d       = pix_en ? (h_wrap ? 10'd0 : h_cnt_q + 10'd1) : h_cnt_q;
      v_cnt_d       = (pix_en && h_wrap) ? (v_cnt_q == V_LAST ? 10'd0 : v_cnt_q + 10'd1) : v_cnt_q;
      valid_d       = h_cnt_d < H_VEND && v_cnt_d < V_VEND;
      hsync_d       = (h_cnt_d >= HS_BEG && h_cnt_d < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (v_cnt_d >= VS_BEG && v_cnt_d < VS_END) ? SYNC_POL : ~SYNC_POL;
      vblank_d      = v_cnt_d >= V_VEND;
      frame_start_d = wrap;
      game_tick_d   = wrap && tk_q == T_LAST;
      tk_d          = wrap ? (tk_q == T_LAST ? '0 : tk_q + TW'(1)) : tk_q;
      frame_cnt_d   = frame_cnt_q + {7'd0, wrap};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q         <= '0;
         h_cnt_q       <= H_LAST;
         v_cnt_q       <= V_LAST;
         valid_q       <= 1'b0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         vblank_q      <= 1'b1;
         frame_start_q <= 1'b0;
         game_tick_q   <= 1'b0;
         frame_cnt_q   <= '0;
         tk_q          <= '0;
      end else begin
         div_q         <= div_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         valid_q       <= valid_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         vblank_q      <= vblank_d;
         frame_start_q <= frame_start_d;
         game_tick_q   <= game_tick_d;
         frame_cnt_q   <= frame_cnt_d;
         tk_q          <= tk_d;
      end
   end

   assign h_cnt       = h_cnt_q;
   assign v_cnt       = v_cnt_q;
   assign valid       = valid_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign vblank      = vblank_q;
   assign frame_start = frame_start_q;
   assign game_tick   = game_tick_q;
   assign frame_cnt   = frame_cnt_q;
endmodule
